// File: rtl/melody_sequencer.sv
// Melody table sequencer: walks {dur, div} entries from a synchronous ROM and
// gates a square-wave tone stage for dur beat ticks per note, with a silent gap between notes.
module melody_sequencer #(
  parameter int DIV_W     = 16,
  parameter int DUR_W     = 4,
  parameter int ADDR_W    = 5,
  parameter int TICK_DIV  = 4,
  parameter int GAP_TICKS = 1,
  parameter int LOOP      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DUR_W+DIV_W-1:0] rom_data,
  output logic [DIV_W-1:0]       tone_div,
  output logic                   tone_en,
  output logic                   busy,
  output logic                   done
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int BEAT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [BEAT_W-1:0] GAP_LOAD  = BEAT_W'(GAP_TICKS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_DONE
  } state_t;

  state_t              state_reg, state_next, adv_state;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DIV_W-1:0]    div_reg, div_next;
  logic                en_reg, en_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [TICK_W-1:0]   tick_reg, tick_next;
  logic [BEAT_W-1:0]   beats_reg, beats_next;

  logic [DUR_W-1:0]    rom_dur;
  logic [DIV_W-1:0]    rom_div;
  logic                tick_hit;

  assign rom_dur  = rom_data[DUR_W+DIV_W-1:DIV_W];
  assign rom_div  = rom_data[DIV_W-1:0];
  assign tick_hit = (tick_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      div_reg   <= '0;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      tick_reg  <= TICK_LAST;
      beats_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      div_reg   <= div_next;
      en_reg    <= en_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      tick_reg  <= tick_next;
      beats_reg <= beats_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    div_next   = div_reg;
    en_next    = en_reg;
    tick_next  = tick_reg;
    beats_next = beats_reg;
    // Leaving the last table slot either wraps around or finishes playback.
    adv_state  = (addr_reg == ADDR_LAST && LOOP == 0) ? S_DONE : S_FETCH;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_FETCH;
          addr_next  = '0;
        end
      end
      S_FETCH: state_next = S_LOAD;
      S_LOAD: begin
        if (rom_dur == '0) begin
          if (LOOP != 0 && addr_reg != '0) begin
            state_next = S_FETCH;
            addr_next  = '0;
          end else begin
            state_next = S_DONE;
          end
        end else begin
          state_next = S_PLAY;
          div_next   = rom_div;
          en_next    = (rom_div != '0);
          tick_next  = TICK_LAST;
          beats_next = BEAT_W'(rom_dur);
        end
      end
      S_PLAY, S_GAP: begin
        // The tick reload doubles as the entry reload for a following GAP.
        tick_next = tick_hit ? TICK_LAST : tick_reg - TICK_W'(1);
        if (tick_hit) begin
          if (beats_reg != BEAT_W'(1)) begin
            beats_next = beats_reg - BEAT_W'(1);
          end else if (state_reg == S_PLAY && GAP_TICKS > 0) begin
            state_next = S_GAP;
            en_next    = 1'b0;
            beats_next = GAP_LOAD;
          end else begin
            state_next = adv_state;
            en_next    = 1'b0;
            addr_next  = addr_reg + ADDR_W'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (stop) begin
      state_next = S_IDLE;
      addr_next  = '0;
      div_next   = div_reg;
      en_next    = 1'b0;
    end

    busy_next = (state_next != S_IDLE) && (state_next != S_DONE);
    done_next = (state_next == S_DONE) && (state_reg != S_DONE);
  end

  assign rom_addr = addr_reg;
  assign tone_div = div_reg;
  assign tone_en  = en_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: two instances (LOOP=0 and LOOP=1) share a ROM table;
// expected output traces come from a note/gap timeline model of the playback rules.
module tb_melody_sequencer;

  localparam int TICK = 4;
  localparam int GAP  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start0 = 1'b0, stop0 = 1'b0, start1 = 1'b0, stop1 = 1'b0;
  logic [1:0]  rom_addr0, rom_addr1;
  logic [19:0] rom_data0, rom_data1;
  logic [15:0] tone_div0, tone_div1;
  logic        tone_en0, tone_en1, busy0, busy1, done0, done1;
  logic [19:0] rom_mem [4];

  // Packed view {en, div, busy, done, addr}
  logic [20:0] obs0, obs1;
  assign obs0 = {tone_en0, tone_div0, busy0, done0, rom_addr0};
  assign obs1 = {tone_en1, tone_div1, busy1, done1, rom_addr1};

  int          checks = 0;
  int          errors = 0;
  logic [15:0] div0_m = 16'd0, div1_m = 16'd0;
  logic [20:0] exp_q[$], e0[$], e1[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data0 <= rom_mem[rom_addr0];
    rom_data1 <= rom_mem[rom_addr1];
  end

  melody_sequencer #(.DIV_W(16), .DUR_W(4), .ADDR_W(2), .TICK_DIV(TICK), .GAP_TICKS(GAP), .LOOP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .tone_div(tone_div0), .tone_en(tone_en0), .busy(busy0), .done(done0));

  melody_sequencer #(.DIV_W(16), .DUR_W(4), .ADDR_W(2), .TICK_DIV(TICK), .GAP_TICKS(GAP), .LOOP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .tone_div(tone_div1), .tone_en(tone_en1), .busy(busy1), .done(done1));

  function automatic logic [20:0] pack(input logic en, input logic [15:0] div, input logic bsy,
                                       input logic dn, input int addr);
    logic [1:0] a;
    a = 2'(addr);
    return {en, div, bsy, dn, a};
  endfunction

  // Timeline model: cycle i of exp_q is the output after the i-th edge following start.
  function automatic void build_model(input bit loop_mode, input logic [15:0] div_start, input int ncyc);
    int          addr;
    int          dur;
    logic [15:0] div;
    logic [15:0] d;
    bit          fin;
    exp_q.delete();
    addr = 0;
    div  = div_start;
    fin  = 1'b0;
    while (!fin && exp_q.size() < ncyc) begin
      exp_q.push_back(pack(1'b0, div, 1'b1, 1'b0, addr));
      exp_q.push_back(pack(1'b0, div, 1'b1, 1'b0, addr));
      dur = int'(rom_mem[addr][19:16]);
      d   = rom_mem[addr][15:0];
      if (dur == 0) begin
        if (loop_mode && addr != 0) addr = 0;
        else begin
          exp_q.push_back(pack(1'b0, div, 1'b0, 1'b1, addr));
          fin = 1'b1;
        end
      end else begin
        div = d;
        for (int c = 0; c < dur * TICK; c++) exp_q.push_back(pack(d != 16'd0, div, 1'b1, 1'b0, addr));
        for (int c = 0; c < GAP * TICK; c++) exp_q.push_back(pack(1'b0, div, 1'b1, 1'b0, addr));
        if (addr == 3 && !loop_mode) begin
          addr = 0;
          exp_q.push_back(pack(1'b0, div, 1'b0, 1'b1, addr));
          fin = 1'b1;
        end else begin
          addr = (addr + 1) % 4;
        end
      end
    end
    while (exp_q.size() < ncyc) exp_q.push_back(pack(1'b0, div, 1'b0, 1'b0, addr));
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if (obs0 !== 21'd0) begin errors++; $display("FAIL reset_async0 got %h want %h", obs0, 21'd0); end
    checks++;
    if (obs1 !== 21'd0) begin errors++; $display("FAIL reset_async1 got %h want %h", obs1, 21'd0); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs0 !== 21'd0) begin errors++; $display("FAIL reset_idle0 got %h want %h", obs0, 21'd0); end
    checks++;
    if (obs1 !== 21'd0) begin errors++; $display("FAIL reset_idle1 got %h want %h", obs1, 21'd0); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    rom_mem[0] = {4'd2, 16'd100};
    rom_mem[1] = {4'd1, 16'd50};
    rom_mem[2] = {4'd0, 16'($urandom)};
    rom_mem[3] = {4'd3, 16'd999};
    build_model(1'b0, div0_m, 30);
    e0 = exp_q;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (obs0 !== e0[i]) begin errors++; $display("FAIL basic cyc %0d got %h want %h", i, obs0, e0[i]); end
      @(negedge clk);
    end
    div0_m = e0[29][19:4];
    $display("test_basic done");
  endtask

  task automatic test_latency();
    int edges;
    build_model(1'b0, div0_m, 30);
    e0 = exp_q;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    checks++;
    if (rom_addr0 !== 2'd0 || busy0 !== 1'b1)
      begin errors++; $display("FAIL latency_fetch got addr %0d busy %b want addr 0 busy 1", rom_addr0, busy0); end
    edges = 1;
    while (tone_en0 !== 1'b1 && edges < 10) begin
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges != 3) begin errors++; $display("FAIL latency_en got %0d edges want 3", edges); end
    repeat (30) @(negedge clk);
    div0_m = e0[29][19:4];
    $display("test_latency done edges=%0d", edges);
  endtask

  task automatic test_rest();
    rom_mem[0] = {4'd3, 16'd0};
    rom_mem[1] = {4'd1, 16'd7};
    rom_mem[2] = {4'd0, 16'($urandom)};
    rom_mem[3] = {4'd2, 16'd5};
    build_model(1'b0, div0_m, 36);
    e0 = exp_q;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int i = 0; i < 36; i++) begin
      checks++;
      if (obs0 !== e0[i]) begin errors++; $display("FAIL rest cyc %0d got %h want %h", i, obs0, e0[i]); end
      @(negedge clk);
    end
    div0_m = e0[35][19:4];
    $display("test_rest done");
  endtask

  task automatic test_stop();
    logic [20:0] idle;
    rom_mem[0] = {4'd3, 16'd20};
    rom_mem[1] = {4'd2, 16'd30};
    rom_mem[2] = {4'd0, 16'd0};
    rom_mem[3] = {4'd1, 16'd40};
    build_model(1'b0, div0_m, 12);
    e0 = exp_q;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (obs0 !== e0[i]) begin errors++; $display("FAIL stop_run cyc %0d got %h want %h", i, obs0, e0[i]); end
      if (i == 6) start0 = 1'b1;
      if (i == 7) start0 = 1'b0;
      if (i == 10) stop0 = 1'b1;
      @(negedge clk);
    end
    stop0 = 1'b0;
    idle = {1'b0, e0[10][19:4], 4'b0000};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs0 !== idle) begin errors++; $display("FAIL stop_idle cyc %0d got %h want %h", i, obs0, idle); end
      @(negedge clk);
    end
    build_model(1'b0, idle[19:4], 12);
    e0 = exp_q;
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      checks++;
      if (obs0 !== e0[i]) begin errors++; $display("FAIL stop_rerun cyc %0d got %h want %h", i, obs0, e0[i]); end
      if (i == 5) begin start0 = 1'b1; stop0 = 1'b1; end
      @(negedge clk);
    end
    idle = {1'b0, e0[5][19:4], 4'b0000};
    checks++;
    if (obs0 !== idle) begin errors++; $display("FAIL stop_start_busy got %h want %h", obs0, idle); end
    @(negedge clk);
    checks++;
    if (obs0 !== idle) begin errors++; $display("FAIL stop_start_idle got %h want %h", obs0, idle); end
    start0 = 1'b0; stop0 = 1'b0;
    div0_m = idle[19:4];
    $display("test_stop done");
  endtask

  task automatic test_random_tables();
    int          dur;
    int          dv;
    logic [20:0] idle0, idle1;
    for (int it = 0; it < 5; it++) begin
      for (int a = 0; a < 4; a++) begin
        if (it == 0) begin
          dur = $urandom_range(1, 2);
          dv  = $urandom_range(1, 65535);
        end else begin
          dur = (a == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
          dv  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 65535);
        end
        rom_mem[a] = {4'(dur), 16'(dv)};
      end
      build_model(1'b0, div0_m, 81);
      e0 = exp_q;
      build_model(1'b1, div1_m, 81);
      e1 = exp_q;
      @(negedge clk); start0 = 1'b1; start1 = 1'b1;
      @(negedge clk); start0 = 1'b0; start1 = 1'b0;
      for (int i = 0; i < 80; i++) begin
        checks++;
        if (obs0 !== e0[i]) begin errors++; $display("FAIL rand%0d dut0 cyc %0d got %h want %h", it, i, obs0, e0[i]); end
        checks++;
        if (obs1 !== e1[i]) begin errors++; $display("FAIL rand%0d dut1 cyc %0d got %h want %h", it, i, obs1, e1[i]); end
        @(negedge clk);
      end
      stop0 = 1'b1; stop1 = 1'b1;
      @(negedge clk);
      stop0 = 1'b0; stop1 = 1'b0;
      idle0 = {1'b0, e0[80][19:4], 4'b0000};
      idle1 = {1'b0, e1[80][19:4], 4'b0000};
      checks++;
      if (obs0 !== idle0) begin errors++; $display("FAIL rand%0d stop0 got %h want %h", it, obs0, idle0); end
      checks++;
      if (obs1 !== idle1) begin errors++; $display("FAIL rand%0d stop1 got %h want %h", it, obs1, idle1); end
      div0_m = idle0[19:4];
      div1_m = idle1[19:4];
      $display("test_random_tables iter %0d table %h %h %h %h", it, rom_mem[0], rom_mem[1], rom_mem[2], rom_mem[3]);
    end
  endtask

  task automatic test_async_reset();
    rom_mem[0] = {4'd2, 16'd1234};
    rom_mem[1] = {4'd1, 16'd77};
    rom_mem[2] = {4'd0, 16'd0};
    rom_mem[3] = {4'd1, 16'd9};
    build_model(1'b0, div0_m, 30);
    e0 = exp_q;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs0 !== e0[i]) begin errors++; $display("FAIL arst_pre cyc %0d got %h want %h", i, obs0, e0[i]); end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs0 !== 21'd0) begin errors++; $display("FAIL arst_drop0 got %h want %h", obs0, 21'd0); end
    checks++;
    if (obs1 !== 21'd0) begin errors++; $display("FAIL arst_drop1 got %h want %h", obs1, 21'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    div0_m = 16'd0;
    div1_m = 16'd0;
    build_model(1'b0, div0_m, 30);
    e0 = exp_q;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (obs0 !== e0[i]) begin errors++; $display("FAIL arst_replay cyc %0d got %h want %h", i, obs0, e0[i]); end
      @(negedge clk);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_basic();
    test_latency();
    test_rest();
    test_stop();
    test_random_tables();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
